aes_subbytes_scheduler: RTL and testbench

//   Shares one combinational sbox_fwd instance between two requesters: cipher SubBytes
//   (128-bit state) and key-expansion SubWord (32-bit word). Accepts one job at a time,

---
 rtl/aes_subbytes_scheduler_pkg.sv | 21 ++
 rtl/aes_subbytes_scheduler_if.sv | 30 +++
 rtl/aes_rr_arb2.sv | 35 +++
 rtl/sbox_fwd.sv | 36 +++
 rtl/aes_subbytes_scheduler.sv | 117 +++++++++++
 tb/tb_aes_subbytes_scheduler.sv | 286 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_subbytes_scheduler_pkg.sv
// Shared types and constants for the SubBytes/SubWord S-box scheduler.
// Imported by the arbiter, the top level and the bus interface users.
package aes_subbytes_scheduler_pkg;

  localparam int CNT_W        = 4;
  localparam int ST_BYTES_DEF = 16;
  localparam int KW_BYTES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  typedef enum logic {
    REQ_ST = 1'b0,
    REQ_KW = 1'b1
  } req_id_t;

endpackage

// File: rtl/aes_subbytes_scheduler_if.sv
// Request/response channels for the cipher-state and key-word requesters.
// The master side belongs to the requesters, the slave side to the scheduler.
interface aes_subbytes_scheduler_if;
  logic         st_req_valid;
  logic         st_req_ready;
  logic [127:0] st_req_data;
  logic         st_rsp_valid;
  logic         st_rsp_ready;
  logic [127:0] st_rsp_data;
  logic         kw_req_valid;
  logic         kw_req_ready;
  logic [31:0]  kw_req_data;
  logic         kw_rsp_valid;
  logic         kw_rsp_ready;
  logic [31:0]  kw_rsp_data;

  modport master (
    output st_req_valid, st_req_data, st_rsp_ready,
    output kw_req_valid, kw_req_data, kw_rsp_ready,
    input  st_req_ready, st_rsp_valid, st_rsp_data,
    input  kw_req_ready, kw_rsp_valid, kw_rsp_data
  );

  modport slave (
    input  st_req_valid, st_req_data, st_rsp_ready,
    input  kw_req_valid, kw_req_data, kw_rsp_ready,
    output st_req_ready, st_rsp_valid, st_rsp_data,
    output kw_req_ready, kw_rsp_valid, kw_rsp_data
  );
endinterface

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin grant for the state and key-word requesters.
// A lone valid always wins; on a tie the registered priority decides.
module aes_rr_arb2
  import aes_subbytes_scheduler_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en,
  input  logic    st_valid,
  input  logic    kw_valid,
  output logic    st_ready,
  output logic    kw_ready,
  output logic    accept,
  output req_id_t grant
);

  req_id_t prio_q;
  logic    st_acc;
  logic    kw_acc;

  assign st_ready = en & (!kw_valid | (prio_q == REQ_ST));
  assign kw_ready = en & (!st_valid | (prio_q == REQ_KW));
  assign st_acc   = st_valid & st_ready;
  assign kw_acc   = kw_valid & kw_ready;
  assign accept   = st_acc | kw_acc;
  assign grant    = st_acc ? REQ_ST : REQ_KW;

  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      prio_q <= REQ_ST;
    else if (accept) prio_q <= (grant == REQ_ST) ? REQ_KW : REQ_ST;
  end

endmodule

// File: rtl/sbox_fwd.sv
// Combinational AES forward S-box: multiplicative inverse in GF(2^8)
// (as x^254) followed by the affine transform with constant 8'h63.
module sbox_fwd (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 for x != 0 and maps 0 to 0, which is what AES wants.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int k = 0; k < 6; k++) r = gf_mul(gf_mul(r, r), a);
    return gf_mul(r, r);
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv      = gf_inv(in_byte);
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_subbytes_scheduler.sv
// Time-shares one forward S-box between cipher SubBytes (16 bytes) and key
// SubWord (4 bytes): one job at a time, one byte per cycle, whole-word response.
module aes_subbytes_scheduler
  import aes_subbytes_scheduler_pkg::*;
#(
  parameter int SBOX_PIPE = 1,
  parameter int ST_BYTES  = ST_BYTES_DEF,
  parameter int KW_BYTES  = KW_BYTES_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  aes_subbytes_scheduler_if.slave   bus,
  output logic                      busy
);

  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(ST_BYTES - 1);
  localparam logic [CNT_W-1:0] KW_LAST = CNT_W'(KW_BYTES - 1);

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] last_q;
  logic [15:0][7:0] buf_q;
  logic [7:0]       pipe_q;
  logic [7:0]       sbox_in;
  logic [7:0]       sbox_out;
  req_id_t          owner_q;
  logic             accept;
  req_id_t          grant;
  logic             rsp_fire;

  aes_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_q == IDLE),
    .st_valid (bus.st_req_valid),
    .kw_valid (bus.kw_req_valid),
    .st_ready (bus.st_req_ready),
    .kw_ready (bus.kw_req_ready),
    .accept   (accept),
    .grant    (grant)
  );

  // Input held at zero outside RUN so the S-box cone does not toggle.
  assign sbox_in = (state_q == RUN) ? buf_q[cnt_q] : 8'h00;

  sbox_fwd u_sbox (
    .in_byte  (sbox_in),
    .out_byte (sbox_out)
  );

  assign busy             = (state_q != IDLE);
  assign bus.st_rsp_valid = (state_q == RESP) && (owner_q == REQ_ST);
  assign bus.kw_rsp_valid = (state_q == RESP) && (owner_q == REQ_KW);
  assign bus.st_rsp_data  = buf_q;
  assign bus.kw_rsp_data  = buf_q[3:0];
  assign rsp_fire = (bus.st_rsp_valid & bus.st_rsp_ready)
                  | (bus.kw_rsp_valid & bus.kw_rsp_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == last_q) state_d = (SBOX_PIPE != 0) ? DRAIN : RESP;
      DRAIN:   state_d = RESP;
      RESP:    if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the work buffer is reset even though it is storage, so that a
  // discarded job leaves no trace on the response data buses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      last_q  <= '0;
      buf_q   <= '0;
      pipe_q  <= 8'h00;
      owner_q <= REQ_ST;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q <= grant;
            cnt_q   <= '0;
            if (grant == REQ_ST) begin
              buf_q  <= bus.st_req_data;
              last_q <= ST_LAST;
            end else begin
              buf_q  <= {96'h0, bus.kw_req_data};
              last_q <= KW_LAST;
            end
          end
        end
        RUN: begin
          if (cnt_q != last_q) cnt_q <= cnt_q + 1'b1;
          if (SBOX_PIPE == 0) begin
            buf_q[cnt_q] <= sbox_out;
          end else begin
            // Registered S-box: each result lands one byte behind the read pointer.
            pipe_q <= sbox_out;
            if (cnt_q != '0) buf_q[cnt_q - 1'b1] <= pipe_q;
          end
        end
        DRAIN:   buf_q[last_q] <= pipe_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_subbytes_scheduler.sv
// Scoreboard bench for aes_subbytes_scheduler: drivers push expected words,
// a negedge monitor pops and compares on every response handshake.
module tb_aes_subbytes_scheduler;

  localparam int P    = 1;
  localparam int ST_N = 16;
  localparam int KW_N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  aes_subbytes_scheduler_if bus ();

  aes_subbytes_scheduler #(.SBOX_PIPE(P), .ST_BYTES(ST_N), .KW_BYTES(KW_N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  logic [7:0] sb_ref [256];

  logic [127:0] st_exp_q [$];
  int unsigned  st_acc_q [$];
  logic [31:0]  kw_exp_q [$];
  int unsigned  kw_acc_q [$];

  typedef struct { bit is_kw; int unsigned at; } grant_t;
  grant_t glog [$];

  bit hold_rsp = 1'b0;
  bit rand_rsp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference S-box built from the field definition: brute-force inverse then affine map.
  function automatic int ref_mul(input int a, input int b);
    int p = 0;
    for (int i = 0; i < 8; i++) if ((b >> i) & 1) p = p ^ (a << i);
    for (int bit_i = 14; bit_i >= 8; bit_i--) if ((p >> bit_i) & 1) p = p ^ (32'h11b << (bit_i - 8));
    return p;
  endfunction

  function automatic logic [7:0] ref_affine(input logic [7:0] b);
    logic [7:0] c = 8'h63;
    logic [7:0] s;
    for (int i = 0; i < 8; i++)
      s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
    return s;
  endfunction

  function automatic logic [127:0] st_model(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sb_ref[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] kw_model(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sb_ref[d[8*i +: 8]];
    return r;
  endfunction

  always @(negedge clk) begin
    bus.st_rsp_ready = hold_rsp ? 1'b0 : (rand_rsp ? 1'($urandom_range(0, 1)) : 1'b1);
    bus.kw_rsp_ready = hold_rsp ? 1'b0 : (rand_rsp ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  task automatic send_st(input logic [127:0] d, input logic [127:0] exp);
    int t = 0;
    @(negedge clk);
    bus.st_req_valid = 1'b1;
    bus.st_req_data  = d;
    #1;
    while (!bus.st_req_ready && t < 300) begin @(negedge clk); #1; t++; end
    if (!bus.st_req_ready) check_eq("st_req_timeout", 0, 1);
    else begin
      st_exp_q.push_back(exp);
      st_acc_q.push_back(cyc + 1);
      glog.push_back('{1'b0, cyc + 1});
    end
    @(posedge clk); #1;
    bus.st_req_valid = 1'b0;
  endtask

  task automatic send_kw(input logic [31:0] d, input logic [31:0] exp);
    int t = 0;
    @(negedge clk);
    bus.kw_req_valid = 1'b1;
    bus.kw_req_data  = d;
    #1;
    while (!bus.kw_req_ready && t < 300) begin @(negedge clk); #1; t++; end
    if (!bus.kw_req_ready) check_eq("kw_req_timeout", 0, 1);
    else begin
      kw_exp_q.push_back(exp);
      kw_acc_q.push_back(cyc + 1);
      glog.push_back('{1'b1, cyc + 1});
    end
    @(posedge clk); #1;
    bus.kw_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin @(negedge clk); #3; t++; end
    while ((busy || st_exp_q.size() != 0 || kw_exp_q.size() != 0) && t < 600);
    if (t >= 600) check_eq("idle_timeout", 0, 1);
  endtask

  // Monitor: response handshakes, latency, hold stability and ready/busy rules.
  logic         st_pv, st_pr, kw_pv, kw_pr;
  logic [127:0] st_pd;
  logic [31:0]  kw_pd;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      st_pv = 1'b0;
      kw_pv = 1'b0;
    end else begin
      if (busy) check_eq("ready_while_busy", {bus.st_req_ready, bus.kw_req_ready}, 2'b00);
      else if (bus.st_req_valid && bus.kw_req_valid)
        check_eq("one_ready", 32'(bus.st_req_ready) + 32'(bus.kw_req_ready), 1);
      if (!busy) check_eq("sbox_in_idle", dut.sbox_in, 8'h00);
      if (bus.st_rsp_valid && bus.kw_rsp_valid) check_eq("both_rsp_valid", 0, 1);

      if (bus.st_rsp_valid) begin
        if (!st_pv) begin
          if (st_acc_q.size() == 0) check_eq("st_unexpected_rsp", 1, 0);
          else check_eq("st_latency", cyc - st_acc_q.pop_front(), ST_N + P);
        end else if (!st_pr) check_eq("st_hold_data", bus.st_rsp_data, st_pd);
        if (bus.st_rsp_ready) begin
          if (st_exp_q.size() == 0) check_eq("st_no_expect", 1, 0);
          else check_eq("st_data", bus.st_rsp_data, st_exp_q.pop_front());
        end
      end
      if (bus.kw_rsp_valid) begin
        if (!kw_pv) begin
          if (kw_acc_q.size() == 0) check_eq("kw_unexpected_rsp", 1, 0);
          else check_eq("kw_latency", cyc - kw_acc_q.pop_front(), KW_N + P);
        end else if (!kw_pr) check_eq("kw_hold_data", bus.kw_rsp_data, kw_pd);
        if (bus.kw_rsp_ready) begin
          if (kw_exp_q.size() == 0) check_eq("kw_no_expect", 1, 0);
          else check_eq("kw_data", bus.kw_rsp_data, kw_exp_q.pop_front());
        end
      end
      st_pv = bus.st_rsp_valid; st_pr = bus.st_rsp_ready; st_pd = bus.st_rsp_data;
      kw_pv = bus.kw_rsp_valid; kw_pr = bus.kw_rsp_ready; kw_pd = bus.kw_rsp_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] d;
    logic [31:0]  w;
    int unsigned  rel;
    int           t;

    for (int x = 0; x < 256; x++) begin
      int inv = 0;
      if (x != 0) for (int y = 1; y < 256; y++) if (ref_mul(x, y) == 1) inv = y;
      sb_ref[x] = ref_affine(8'(inv));
    end

    bus.st_req_valid = 1'b0; bus.st_req_data = '0;
    bus.kw_req_valid = 1'b0; bus.kw_req_data = '0;
    bus.st_rsp_ready = 1'b1; bus.kw_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rsp_valid", {bus.st_rsp_valid, bus.kw_rsp_valid}, 2'b00);
    check_eq("rst_st_data", bus.st_rsp_data, 0);
    check_eq("rst_idle_ready", {bus.st_req_ready, bus.kw_req_ready}, 2'b11);

    // Known-answer vectors.
    send_st(128'h0f0e0d0c0b0a09080706050403020100, 128'h76abd7fe2b670130c56f6bf27b777c63);
    wait_idle();
    send_kw(32'hcf4f3c09, 32'h8a84eb01);
    wait_idle();

    // Round-robin on simultaneous requests.
    glog.delete();
    d = {$urandom, $urandom, $urandom, $urandom}; w = $urandom;
    fork send_st(d, st_model(d)); send_kw(w, kw_model(w)); join
    wait_idle();
    d = {$urandom, $urandom, $urandom, $urandom};
    send_st(d, st_model(d));
    wait_idle();
    d = {$urandom, $urandom, $urandom, $urandom}; w = $urandom;
    fork send_st(d, st_model(d)); send_kw(w, kw_model(w)); join
    wait_idle();
    check_eq("tie1_first_st", glog[0].is_kw, 0);
    check_eq("tie1_second_kw", glog[1].is_kw, 1);
    check_eq("tie1_spacing", glog[1].at - glog[0].at, ST_N + P + 2);
    check_eq("tie2_first_kw", glog[3].is_kw, 1);
    check_eq("tie2_second_st", glog[4].is_kw, 0);

    // Backpressure in RESP with a state request pending.
    hold_rsp = 1'b1;
    w = $urandom;
    send_kw(w, kw_model(w));
    t = 0;
    while (!bus.kw_rsp_valid && t < 50) begin @(negedge clk); #3; t++; end
    check_eq("bp_rsp_valid_seen", bus.kw_rsp_valid, 1);
    d = {$urandom, $urandom, $urandom, $urandom};
    fork send_st(d, st_model(d)); join_none
    repeat (5) @(negedge clk);
    #3;
    check_eq("bp_hold_valid", bus.kw_rsp_valid, 1);
    check_eq("bp_req_ready_low", bus.st_req_ready, 0);
    hold_rsp = 1'b0;
    @(negedge clk);
    rel = cyc;
    wait_idle();
    wait fork;
    check_eq("bp_pending_accept", glog[glog.size() - 1].at - rel, 2);

    // Asynchronous reset in the middle of a state job.
    d = {$urandom, $urandom, $urandom, $urandom};
    send_st(d, st_model(d));
    t = 0;
    while (!(busy && dut.cnt_q == 4'd7) && t < 40) begin @(negedge clk); t++; end
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_rsp_valid", {bus.st_rsp_valid, bus.kw_rsp_valid}, 2'b00);
    check_eq("arst_st_data", bus.st_rsp_data, 0);
    check_eq("arst_kw_data", bus.kw_rsp_data, 0);
    st_exp_q.delete(); st_acc_q.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    send_st({16{8'hff}}, {16{8'h16}});
    wait_idle();

    // Back-to-back key words with the consumer always ready.
    glog.delete();
    for (int i = 0; i < 5; i++) begin
      w = $urandom;
      send_kw(w, kw_model(w));
    end
    wait_idle();
    for (int i = 1; i < 5; i++) check_eq("kw_b2b_spacing", glog[i].at - glog[i-1].at, KW_N + P + 2);

    // Random traffic on both channels with random response backpressure.
    rand_rsp = 1'b1;
    fork
      for (int i = 0; i < 12; i++) begin
        logic [127:0] sd;
        sd = {$urandom, $urandom, $urandom, $urandom};
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_st(sd, st_model(sd));
      end
      for (int j = 0; j < 25; j++) begin
        logic [31:0] kd;
        kd = $urandom;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_kw(kd, kw_model(kd));
      end
    join
    wait_idle();
    rand_rsp = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
